// File: rtl/spark_pwm_pkg.sv
// -----------------------------------------------------------------------------
// spark_pwm_pkg
// Purpose : shared timing constants, counter widths, the capture FSM state
//           type and a small helper for the SparkMax-style PWM path. The
//           transmitter's timing comments refer to the same limits.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package spark_pwm_pkg;

  // Timing in microseconds unless noted otherwise.
  localparam int CLK_DIV_DEF       = 50;     // clock cycles per 1 us tick
  localparam int CENTER_US_DEF     = 1500;   // neutral pulse width
  localparam int DEADBAND_US_DEF   = 25;     // half-width of the stopped band
  localparam int MIN_HIGH_US_DEF   = 900;
  localparam int MAX_HIGH_US_DEF   = 2100;
  localparam int MIN_PERIOD_US_DEF = 5000;   // 200 Hz
  localparam int MAX_PERIOD_US_DEF = 20000;  // 50 Hz
  localparam int TIMEOUT_US_DEF    = 25000;  // no rising edge -> signal lost

  // Counter and output widths.
  localparam int HI_W    = 12;  // high-time counter, saturates at 4095
  localparam int PER_W   = 15;  // period counter, saturates at 32767
  localparam int RATIO_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_e;

  // Unsigned absolute difference, used for the distance from center.
  function automatic logic [HI_W-1:0] abs_diff(input logic [HI_W-1:0] a,
                                               input logic [HI_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// -----------------------------------------------------------------------------
// pwm_edge_sync
// Purpose : brings an asynchronous PWM line into the clock domain through a
//           two-flop synchronizer and produces registered single-cycle
//           rise/fall pulses. Pulses appear three clocks after the pin moves.
// Ports   : i_clock  - clock
//           i_reset  - synchronous active-high reset (all flops to 0)
//           i_async  - asynchronous input line
//           o_rise   - one-cycle pulse on a 0->1 transition
//           o_fall   - one-cycle pulse on a 1->0 transition
// -----------------------------------------------------------------------------
module pwm_edge_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
      r_fall  <= ~r_sync2 & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spark_pwm_capture.sv
// -----------------------------------------------------------------------------
// spark_pwm_capture
// Purpose : measures high time and period of an RC-style PWM line in
//           microseconds and decodes it back to the 8-bit ratio + direction
//           used by the SparkMax transmitter. Flags out-of-spec periods and
//           a lost signal.
// Ports   : i_clock          - clock
//           i_reset          - synchronous active-high reset
//           i_capture_enable - low forces IDLE and clears the counters
//           i_pwm_in         - asynchronous PWM line
//           o_pwm_ratio      - decoded magnitude 0..255
//           o_pwm_direction  - 1 = forward (high time above center)
//           o_pwm_valid      - one-cycle pulse, new legal measurement applied
//           o_pwm_error      - one-cycle pulse, completed period out of spec
//           o_signal_lost    - level, no rising edge for TIMEOUT_US
//           o_high_us        - last measured high time in us
// -----------------------------------------------------------------------------
module spark_pwm_capture
  import spark_pwm_pkg::*;
#(
  parameter int CLK_DIV       = CLK_DIV_DEF,
  parameter int CENTER_US     = CENTER_US_DEF,
  parameter int DEADBAND_US   = DEADBAND_US_DEF,
  parameter int MIN_HIGH_US   = MIN_HIGH_US_DEF,
  parameter int MAX_HIGH_US   = MAX_HIGH_US_DEF,
  parameter int MIN_PERIOD_US = MIN_PERIOD_US_DEF,
  parameter int MAX_PERIOD_US = MAX_PERIOD_US_DEF,
  parameter int TIMEOUT_US    = TIMEOUT_US_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_capture_enable,
  input  logic               i_pwm_in,
  output logic [RATIO_W-1:0] o_pwm_ratio,
  output logic               o_pwm_direction,
  output logic               o_pwm_valid,
  output logic               o_pwm_error,
  output logic               o_signal_lost,
  output logic [HI_W-1:0]    o_high_us
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // ---------------------------------------------------------------------------
  // Input synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic w_rise;
  logic w_fall;

  pwm_edge_sync u_edge_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_pwm_in),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // ---------------------------------------------------------------------------
  // 1 us prescaler; realigned on every rise so the error stays under 1 us.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] r_presc;
  logic             w_tick;

  assign w_tick = (r_presc == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset || w_rise || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Counters. The *_eff values include the tick of the current cycle, so a
  // value latched on an edge equals the full elapsed microseconds.
  // ---------------------------------------------------------------------------
  logic [HI_W-1:0]  r_hi_cnt;
  logic [PER_W-1:0] r_per_cnt;
  logic [HI_W-1:0]  w_hi_eff;
  logic [PER_W-1:0] w_per_eff;

  assign w_hi_eff  = (w_tick && (r_hi_cnt != '1))  ? r_hi_cnt + HI_W'(1)   : r_hi_cnt;
  assign w_per_eff = (w_tick && (r_per_cnt != '1)) ? r_per_cnt + PER_W'(1) : r_per_cnt;

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / control strobes
  // ---------------------------------------------------------------------------
  cap_state_e r_state;
  cap_state_e w_state_next;
  logic       w_timeout;
  logic       w_clear;     // zero both counters
  logic       w_latch_hi;  // capture high time on fall
  logic       w_eval;      // judge a completed period
  logic       w_force_err; // rise while still high: missed fall
  logic       w_set_lost;

  assign w_timeout = (r_per_cnt >= PER_W'(TIMEOUT_US));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!i_capture_enable) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_rise) w_state_next = HIGH;
        HIGH: begin
          if (w_timeout)   w_state_next = IDLE;
          else if (w_rise) w_state_next = HIGH;
          else if (w_fall) w_state_next = LOW;
        end
        LOW: begin
          // A fall here is a glitch and is ignored.
          if (w_timeout)   w_state_next = IDLE;
          else if (w_rise) w_state_next = HIGH;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_clear     = 1'b0;
    w_latch_hi  = 1'b0;
    w_eval      = 1'b0;
    w_force_err = 1'b0;
    w_set_lost  = 1'b0;
    if (!i_capture_enable) begin
      w_clear = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: w_clear = 1'b1;
        HIGH: begin
          if (w_timeout) begin
            w_clear    = 1'b1;
            w_set_lost = 1'b1;
          end else if (w_rise) begin
            w_clear     = 1'b1;
            w_force_err = 1'b1;
          end else if (w_fall) begin
            w_latch_hi = 1'b1;
          end
        end
        LOW: begin
          if (w_timeout) begin
            w_clear    = 1'b1;
            w_set_lost = 1'b1;
          end else if (w_rise) begin
            w_clear = 1'b1;
            w_eval  = 1'b1;
          end
        end
        default: w_clear = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || w_clear) begin
      r_hi_cnt  <= '0;
      r_per_cnt <= '0;
    end else begin
      if (r_state == HIGH) r_hi_cnt <= w_hi_eff;
      if ((r_state == HIGH) || (r_state == LOW)) r_per_cnt <= w_per_eff;
    end
  end

  // ---------------------------------------------------------------------------
  // Legality check and decode of the completed period
  // ---------------------------------------------------------------------------
  logic [HI_W-1:0]    r_high_us;
  logic [HI_W-1:0]    w_delta;
  logic [HI_W-2:0]    w_half;
  logic               w_legal;
  logic [RATIO_W-1:0] w_ratio;
  logic               w_dir;

  assign w_delta = abs_diff(r_high_us, HI_W'(CENTER_US));
  assign w_half  = w_delta[HI_W-1:1];

  assign w_legal = (r_high_us >= HI_W'(MIN_HIGH_US))     &&
                   (r_high_us <= HI_W'(MAX_HIGH_US))     &&
                   (w_per_eff >= PER_W'(MIN_PERIOD_US))  &&
                   (w_per_eff <= PER_W'(MAX_PERIOD_US));

  always_comb begin
    w_ratio = '0;
    w_dir   = 1'b0;
    if (w_delta > HI_W'(DEADBAND_US)) begin
      w_ratio = (w_half > (HI_W-1)'(255)) ? '1 : w_half[RATIO_W-1:0];
      w_dir   = (r_high_us > HI_W'(CENTER_US));
    end
  end

  // ---------------------------------------------------------------------------
  // Registered results. Outputs change together with the valid pulse.
  // ---------------------------------------------------------------------------
  logic [RATIO_W-1:0] r_ratio;
  logic               r_dir;
  logic               r_valid;
  logic               r_error;
  logic               r_lost;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ratio   <= '0;
      r_dir     <= 1'b0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_lost    <= 1'b0;
      r_high_us <= '0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      if (w_latch_hi) r_high_us <= w_hi_eff;
      if (w_set_lost) r_lost <= 1'b1;
      if (w_force_err) begin
        r_error <= 1'b1;
      end else if (w_eval) begin
        if (w_legal) begin
          r_valid <= 1'b1;
          r_ratio <= w_ratio;
          r_dir   <= w_dir;
          r_lost  <= 1'b0;
        end else begin
          r_error <= 1'b1;
        end
      end
    end
  end

  assign o_pwm_ratio     = r_ratio;
  assign o_pwm_direction = r_dir;
  assign o_pwm_valid     = r_valid;
  assign o_pwm_error     = r_error;
  assign o_signal_lost   = r_lost;
  assign o_high_us       = r_high_us;

endmodule
